// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: two-port arbiter in front of a synchronous font ROM.
// Port 0 (video text pipeline) always wins and is never stalled; port 1
// (HUD/menu writer) is buffered in a one-entry hold register and issued
// on the first cycle port 0 is idle.
// Optional build macro FONT_ARB_REGOUT_EN adds one output register stage
// (response latency 2 cycles after issue instead of 1).
module font_rom_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              p1_starve
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    localparam logic [31:0] LP_LIMIT = 32'(STARVE_LIMIT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_p1_addr;
    logic                r_gnt0;
    logic                r_gnt1;
    logic [15:0]         r_wait_cnt;
    logic [DATA_W-1:0]   r_d0;
    logic [DATA_W-1:0]   r_d1;
    logic                w_accept;
    logic                w_issue1;
    logic                w_pend;

    // Ready depends only on registered state, so there is no path from req1_valid.
    assign w_pend     = (r_state == ST_WAIT);
    assign req1_ready = ~w_pend;
    assign w_accept   = req1_valid && req1_ready;
    assign w_issue1   = w_pend && !req0_valid;

    // Port 0 drives the ROM whenever it is active; otherwise the held port-1 address.
    assign rom_en     = req0_valid || w_pend;
    assign rom_addr   = req0_valid ? req0_addr : r_p1_addr;

    assign p1_starve  = ({16'd0, r_wait_cnt} >= LP_LIMIT);

    // Hold-register state: EMPTY accepts, WAIT issues on the first port-0 idle cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_issue1) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Capture the port-1 address at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_p1_addr <= '0;
        else if (w_accept) r_p1_addr <= req1_addr;
    end

    // Grant tags mark which port owns the ROM data arriving next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
        end else begin
            r_gnt0 <= req0_valid;
            r_gnt1 <= w_issue1;
        end
    end

    // Saturating count of cycles port 1 spent waiting behind port 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_wait_cnt <= '0;
        else if (w_issue1)                       r_wait_cnt <= '0;
        else if (w_pend && r_wait_cnt != 16'hFFFF) r_wait_cnt <= r_wait_cnt + 16'd1;
    end

    // Per-port data registers keep the last delivered font row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0 <= '0;
            r_d1 <= '0;
        end else begin
            if (r_gnt0) r_d0 <= rom_data;
            if (r_gnt1) r_d1 <= rom_data;
        end
    end

`ifdef FONT_ARB_REGOUT_EN
    logic r_v0;
    logic r_v1;

    // Extra output stage: valids delayed one cycle to line up with the data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
        end else begin
            r_v0 <= r_gnt0;
            r_v1 <= r_gnt1;
        end
    end

    assign rsp0_valid = r_v0;
    assign rsp1_valid = r_v1;
    assign rsp0_data  = r_d0;
    assign rsp1_data  = r_d1;
`else
    assign rsp0_valid = r_gnt0;
    assign rsp1_valid = r_gnt1;
    assign rsp0_data  = r_gnt0 ? rom_data : r_d0;
    assign rsp1_data  = r_gnt1 ? rom_data : r_d1;
`endif

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Testbench for font_rom_arbiter: table-driven arbitration vectors plus
// hand-written sequences for latency, starvation, interleave and reset.
module tb_font_rom_arbiter;

`ifdef FONT_ARB_REGOUT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic [10:0] req0_addr = '0;
    logic        rsp0_valid;
    logic [7:0]  rsp0_data;
    logic        req1_valid = 1'b0;
    logic [10:0] req1_addr = '0;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [7:0]  rsp1_data;
    logic        rom_en;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic        p1_starve;

    int n_total = 0;
    int n_pass  = 0;
    int n_rsp1  = 0;

    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [7:0]  last0 = '0;
    logic [7:0]  last1 = '0;

    font_rom_arbiter #(.ADDR_W(11), .DATA_W(8), .STARVE_LIMIT(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .p1_starve(p1_starve)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'hA5;
    endfunction

    // Synchronous ROM model: data one cycle after enable.
    always @(posedge clk) if (rom_en) rom_data <= rom_f(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Response scoreboard: order, data, hold and mutual exclusion.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete(); q1.delete();
            last0 = '0; last1 = '0;
        end else begin
            chk("rsp_both", {31'd0, rsp0_valid & rsp1_valid}, 0);
            if (rsp0_valid) begin
                if (q0.size() == 0) chk("rsp0_spurious", 0, 1);
                else chk("rsp0_data", {24'd0, rsp0_data}, {24'd0, rom_f(q0.pop_front())});
                last0 = rsp0_data;
            end else chk("rsp0_hold", {24'd0, rsp0_data}, {24'd0, last0});
            if (rsp1_valid) begin
                n_rsp1++;
                if (q1.size() == 0) chk("rsp1_spurious", 0, 1);
                else chk("rsp1_data", {24'd0, rsp1_data}, {24'd0, rom_f(q1.pop_front())});
                last1 = rsp1_data;
            end else chk("rsp1_hold", {24'd0, rsp1_data}, {24'd0, last1});
            if (req0_valid) q0.push_back(req0_addr);
            if (req1_valid && req1_ready) q1.push_back(req1_addr);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        r0v;
        logic [10:0] r0a;
        logic        r1v;
        logic [10:0] r1a;
        logic        en;
        logic [10:0] addr;
        logic        rdy;
    } vec_t;

    vec_t vt[12];

    task automatic drive(input logic r0v, input logic [10:0] r0a,
                         input logic r1v, input logic [10:0] r1a);
        req0_valid = r0v; req0_addr = r0a;
        req1_valid = r1v; req1_addr = r1a;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 11'd0, 1'b0, 11'd0);
        repeat (n) next_cycle();
    endtask

    initial begin
        int errs;
        int first;
        int idx;
        int start;
        logic acc;

        vt[0]  = '{1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1};
        vt[1]  = '{1'b1, 11'h123, 1'b0, 11'h000, 1'b1, 11'h123, 1'b1};
        vt[2]  = '{1'b0, 11'h000, 1'b1, 11'h2A3, 1'b0, 11'h000, 1'b1};
        vt[3]  = '{1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 11'h2A3, 1'b0};
        vt[4]  = '{1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h2A3, 1'b1};
        vt[5]  = '{1'b1, 11'h010, 1'b1, 11'h055, 1'b1, 11'h010, 1'b1};
        vt[6]  = '{1'b1, 11'h011, 1'b1, 11'h066, 1'b1, 11'h011, 1'b0};
        vt[7]  = '{1'b1, 11'h012, 1'b1, 11'h066, 1'b1, 11'h012, 1'b0};
        vt[8]  = '{1'b0, 11'h000, 1'b1, 11'h066, 1'b1, 11'h055, 1'b0};
        vt[9]  = '{1'b0, 11'h000, 1'b1, 11'h066, 1'b0, 11'h055, 1'b1};
        vt[10] = '{1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 11'h066, 1'b0};
        vt[11] = '{1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h066, 1'b1};

        // Reset state, during and after reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  {31'd0, req1_ready}, 1);
        chk("rst_starve", {31'd0, p1_starve},  0);
        chk("rst_rsp0v",  {31'd0, rsp0_valid}, 0);
        chk("rst_rsp1v",  {31'd0, rsp1_valid}, 0);
        chk("rst_data",   {16'd0, rsp0_data, rsp1_data}, 0);
        chk("rst_rom_en", {31'd0, rom_en}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready",  {31'd0, req1_ready}, 1);
        chk("post_rst_starve", {31'd0, p1_starve},  0);
        next_cycle();

        // Table: cycle-by-cycle arbitration and ready behaviour.
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].r0v, vt[i].r0a, vt[i].r1v, vt[i].r1a);
            @(negedge clk);
            chk($sformatf("vec%0d_rom_en", i),   {31'd0, rom_en},     {31'd0, vt[i].en});
            chk($sformatf("vec%0d_rom_addr", i), {21'd0, rom_addr},   {21'd0, vt[i].addr});
            chk($sformatf("vec%0d_ready", i),    {31'd0, req1_ready}, {31'd0, vt[i].rdy});
            next_cycle();
        end
        idle(4);

        // Port-1 latency from an idle port 0.
        drive(1'b0, 11'd0, 1'b1, 11'h2A3);
        @(negedge clk);
        chk("lat_accept_ready", {31'd0, req1_ready}, 1);
        next_cycle();
        drive(1'b0, 11'd0, 1'b0, 11'd0);
        first = -1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("lat_issue_en",   {31'd0, rom_en},     1);
                chk("lat_issue_addr", {21'd0, rom_addr},   11'h2A3);
                chk("lat_issue_rdy",  {31'd0, req1_ready}, 0);
            end
            if (k == 2) chk("lat_ready_back", {31'd0, req1_ready}, 1);
            if (rsp1_valid && first < 0) first = k;
            next_cycle();
        end
        chk("lat_rsp1_cycle", first, 1 + LAT);
        idle(3);

        // Continuous port-0 stream with a port-1 request parked behind it.
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 11'(i), (i == 0), 11'h7FF);
            @(negedge clk);
            if (rom_en !== 1'b1 || rom_addr !== 11'(i)) errs++;
            if (rsp0_valid !== (i >= LAT)) errs++;
            next_cycle();
        end
        chk("stream_errors", errs, 0);
        chk("stream_p1_held", {31'd0, req1_ready}, 0);
        drive(1'b0, 11'd0, 1'b0, 11'd0);
        @(negedge clk);
        chk("stream_p1_issue", {21'd0, rom_addr}, 11'h7FF);
        next_cycle();
        idle(4);

        // Starvation: port 1 waits behind 1100 cycles of port-0 traffic.
        drive(1'b1, 11'h000, 1'b1, 11'h3C5);
        next_cycle();
        first = -1;
        errs = 0;
        for (int j = 1; j <= 1100; j++) begin
            drive(1'b1, 11'(j), 1'b0, 11'd0);
            @(negedge clk);
            if (p1_starve && first < 0) first = j;
            if (rom_addr !== 11'(j) || req1_ready !== 1'b0) errs++;
            next_cycle();
        end
        chk("starve_first_cycle", first, 1025);
        chk("starve_prio_errors", errs, 0);
        drive(1'b0, 11'd0, 1'b0, 11'd0);
        @(negedge clk);
        chk("starve_issue_en",   {31'd0, rom_en},    1);
        chk("starve_issue_addr", {21'd0, rom_addr},  11'h3C5);
        chk("starve_still_high", {31'd0, p1_starve}, 1);
        next_cycle();
        @(negedge clk);
        chk("starve_cleared", {31'd0, p1_starve},  0);
        chk("starve_cnt_zero", {16'd0, dut.r_wait_cnt}, 0);
        chk("starve_ready",   {31'd0, req1_ready}, 1);
        next_cycle();
        idle(4);

        // Alternating port 0 with back-to-back port-1 requests 0x100..0x10F.
        start = n_rsp1;
        idx = 0;
        for (int c = 0; c < 100 && idx < 16; c++) begin
            drive((c % 2) == 0, 11'(11'h400 + c), 1'b1, 11'(11'h100 + idx));
            @(negedge clk);
            acc = req1_valid && req1_ready;
            next_cycle();
            if (acc) idx++;
        end
        chk("alt_accepts", idx, 16);
        idle(6);
        chk("alt_rsp1_count", n_rsp1 - start, 16);
        chk("alt_q1_drained", q1.size(), 0);
        chk("alt_q0_drained", q0.size(), 0);

        // Reset one cycle after a port-1 accept discards the request.
        drive(1'b0, 11'd0, 1'b1, 11'h1AB);
        next_cycle();
        drive(1'b0, 11'd0, 1'b0, 11'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'd0, req1_ready}, 1);
        chk("midrst_rom_en", {31'd0, rom_en}, 0);
        next_cycle();
        rst_n = 1'b1;
        errs = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp1_valid !== 1'b0) errs++;
            next_cycle();
        end
        chk("midrst_no_rsp1", errs, 0);
        chk("midrst_ready_after", {31'd0, req1_ready}, 1);
        chk("midrst_starve", {31'd0, p1_starve}, 0);
        chk("midrst_cnt", {16'd0, dut.r_wait_cnt}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
